// File: rtl/des_f_round.sv
// DES round: stage 1 registers X = E(R) ^ K, stage 2 applies S-boxes,
// P and the Feistel XOR. Valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake for l_in, r_in, subkey, swap_en
//   l_in, r_in [1:32]   input halves (bit 1 = MSB)
//   subkey [1:48]       round key
//   swap_en             1 = normal round, 0 = final round (no swap)
//   out_valid/out_ready output handshake for l_out, r_out
//   l_out, r_out [1:32] round result halves
module des_f_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:32] l_in,
    input  logic [1:32] r_in,
    input  logic [1:48] subkey,
    input  logic        swap_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] l_out,
    output logic [1:32] r_out
);

    // Each table holds 64 nibbles, row-major (row 0 col 0 first).
    localparam logic [0:7][255:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Row = outer bits {b1,b6}, column = inner bits b2..b5.
    function automatic logic [3:0] sbox_lu(input logic [255:0] tbl,
                                           input logic [5:0]   grp);
        logic [5:0]   idx;
        logic [255:0] t;
        idx = {grp[5], grp[0], grp[4:1]};
        t   = tbl << {idx, 2'b00};
        return t[255:252];
    endfunction

    logic        adv1;
    logic        adv2;

    logic        s1_v_q;
    logic [1:48] x_q;
    logic [1:32] l1_q;
    logic [1:32] r1_q;
    logic        sw1_q;

    logic        s2_v_q;
    logic [1:32] lo_q;
    logic [1:32] ro_q;

    logic [1:48] x_d;
    logic [1:32] s_w;
    logic [1:32] f_w;
    logic [1:32] lx_w;
    logic [1:32] lo_d;
    logic [1:32] ro_d;

    assign adv2     = !s2_v_q || out_ready;
    assign adv1     = !s1_v_q || adv2;
    assign in_ready = adv1;

    assign out_valid = s2_v_q;
    assign l_out     = lo_q;
    assign r_out     = ro_q;

    // E expansion, then key mix.
    assign x_d = {r_in[32], r_in[1:5], r_in[4:9], r_in[8:13],
                  r_in[12:17], r_in[16:21], r_in[20:25],
                  r_in[24:29], r_in[28:32], r_in[1]} ^ subkey;

    for (genvar g = 0; g < 8; g++) begin : gen_sbox
        logic [5:0] grp;
        assign grp = x_q[6*g+1 +: 6];
        assign s_w[4*g+1 +: 4] = sbox_lu(SBOX[g], grp);
    end

    assign f_w = {s_w[16], s_w[7],  s_w[20], s_w[21],
                  s_w[29], s_w[12], s_w[28], s_w[17],
                  s_w[1],  s_w[15], s_w[23], s_w[26],
                  s_w[5],  s_w[18], s_w[31], s_w[10],
                  s_w[2],  s_w[8],  s_w[24], s_w[14],
                  s_w[32], s_w[27], s_w[3],  s_w[9],
                  s_w[19], s_w[13], s_w[30], s_w[6],
                  s_w[22], s_w[11], s_w[4],  s_w[25]};

    assign lx_w = l1_q ^ f_w;
    assign lo_d = sw1_q ? r1_q : lx_w;
    assign ro_d = sw1_q ? lx_w : r1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            x_q    <= '0;
            l1_q   <= '0;
            r1_q   <= '0;
            sw1_q  <= 1'b0;
        end else if (adv1) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                x_q   <= x_d;
                l1_q  <= l_in;
                r1_q  <= r_in;
                sw1_q <= swap_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q <= 1'b0;
            lo_q   <= '0;
            ro_q   <= '0;
        end else if (adv2) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                lo_q <= lo_d;
                ro_q <= ro_d;
            end
        end
    end

endmodule

// File: tb/tb_des_f_round.sv
// Self-checking bench for des_f_round: scoreboard of expected round
// results against an independent table-driven f-function model.
module tb_des_f_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:32] l_in;
    logic [1:32] r_in;
    logic [1:48] subkey;
    logic        swap_en;
    logic        out_valid;
    logic        out_ready;
    logic [1:32] l_out;
    logic [1:32] r_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [63:0] sb[$];

    des_f_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .l_in      (l_in),
        .r_in      (r_in),
        .subkey    (subkey),
        .swap_en   (swap_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .l_out     (l_out),
        .r_out     (r_out)
    );

    always #5 clk = ~clk;

    int E_T[48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                    8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    int P_T[32] = '{16, 7, 20, 21, 29, 12, 28, 17,
                    1, 15, 23, 26, 5, 18, 31, 10,
                    2, 8, 24, 14, 32, 27, 3, 9,
                    19, 13, 30, 6, 22, 11, 4, 25};

    int SB[8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
        0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
        15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
        3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
        13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
        13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
        1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
        13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
        3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
        14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
        11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
        10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
        4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
        13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
        6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
        1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
        2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // Reference f(R,K); FIPS bit k maps to vector index (width - k).
    function automatic logic [31:0] f_ref(input logic [31:0] r,
                                          input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] f;
        logic [5:0]  g;
        int          row;
        int          col;
        int          v;
        for (int i = 0; i < 48; i++)
            x[47-i] = r[32-E_T[i]] ^ k[47-i];
        for (int j = 0; j < 8; j++) begin
            g   = x[47-6*j -: 6];
            row = 2 * int'(g[5]) + int'(g[0]);
            col = int'(g[4:1]);
            v   = SB[j][row*16+col];
            s[31-4*j -: 4] = v[3:0];
        end
        for (int i = 0; i < 32; i++)
            f[31-i] = s[32-P_T[i]];
        return f;
    endfunction

    function automatic logic [63:0] round_ref(input logic [31:0] l,
                                              input logic [31:0] r,
                                              input logic [47:0] k,
                                              input logic        sw);
        logic [31:0] lx;
        lx = l ^ f_ref(r, k);
        return sw ? {r, lx} : {lx, r};
    endfunction

    // One clock: record accepted inputs, score delivered outputs.
    task automatic cycle();
        logic [63:0] exp_v;
        #1;
        if (in_valid && in_ready)
            sb.push_back(round_ref(l_in, r_in, subkey, swap_en));
        if (out_valid && out_ready) begin
            n_cmp++;
            n_pop++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_out got %h_%h want none",
                         l_out, r_out);
            end else begin
                exp_v = sb.pop_front();
                if ({l_out, r_out} !== exp_v) begin
                    n_err++;
                    $display("FAIL sb_data got %h_%h want %h_%h",
                             l_out, r_out, exp_v[63:32], exp_v[31:0]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if ({l_out, r_out} !== 64'h0) begin
            n_err++;
            $display("FAIL rst_data got %h_%h want 0", l_out, r_out);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_in_ready got %b want 1", in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_kat(input logic sw, input logic [31:0] el,
                            input logic [31:0] er);
        l_in      = 32'hCC00CCFF;
        r_in      = 32'hF0AAF0AA;
        subkey    = 48'h1B02EFFC7072;
        swap_en   = sw;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL kat_lat1 got %b want 0", out_valid);
        end
        cycle();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL kat_lat2 got %b want 1", out_valid);
        end
        n_cmp++;
        if (l_out !== el || r_out !== er) begin
            n_err++;
            $display("FAIL kat_sw%0b got %h_%h want %h_%h",
                     sw, l_out, r_out, el, er);
        end
        drain();
    endtask

    task automatic test_stream();
        int first = -1;
        int last  = -1;
        int nout  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_valid = (i < 16);
            l_in     = $urandom;
            r_in     = $urandom;
            subkey   = {16'($urandom), 32'($urandom)};
            swap_en  = 1'($urandom);
            #1;
            if (i < 16) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_in_ready i=%0d got %b want 1",
                             i, in_ready);
                end
            end
            if (out_valid) begin
                nout++;
                if (first < 0) first = i;
                last = i;
            end
            cycle();
        end
        n_cmp++;
        if (nout != 16 || first != 2 || last != 17) begin
            n_err++;
            $display("FAIL stream_timing got n=%0d %0d..%0d want 16 2..17",
                     nout, first, last);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int pop0;
        pop0      = n_pop;
        out_ready = 1'b0;
        swap_en   = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            l_in   = $urandom;
            r_in   = $urandom;
            subkey = {16'($urandom), 32'($urandom)};
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_accept%0d got %b want 1", i, in_ready);
            end
            cycle();
        end
        l_in   = $urandom;
        r_in   = $urandom;
        subkey = {16'($urandom), 32'($urandom)};
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_stall rdy got %b vld %b want 0 1",
                         in_ready, out_valid);
            end
            n_cmp++;
            if (l_out !== sb[0][63:32]) begin
                n_err++;
                $display("FAIL bp_hold got %h want %h", l_out, sb[0][63:32]);
            end
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (in_ready) begin
                cycle();
                break;
            end
            cycle();
        end
        drain();
        n_cmp++;
        if (n_pop - pop0 != 3) begin
            n_err++;
            $display("FAIL bp_count got %0d want 3", n_pop - pop0);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        swap_en   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            l_in   = $urandom | 32'h1;
            r_in   = $urandom | 32'h1;
            subkey = {16'($urandom), 32'($urandom)};
            cycle();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || {l_out, r_out} !== 64'h0) begin
            n_err++;
            $display("FAIL mid_rst got %b %h_%h want 0 0_0",
                     out_valid, l_out, r_out);
        end
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_stale i=%0d got %b want 0", i, out_valid);
            end
            cycle();
        end
        l_in     = 32'h01234567;
        r_in     = 32'h89ABCDEF;
        subkey   = 48'h0F1E2D3C4B5A;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_first_lat got %b want 1", out_valid);
        end
        drain();
    endtask

    task automatic test_sbox_sweep();
        l_in      = '0;
        r_in      = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 0; j < 8; j++) begin
            for (int v = 0; v < 64; v++) begin
                subkey  = 48'(v) << (42 - 6*j);
                swap_en = 1'(v);
                cycle();
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            l_in      = $urandom;
            r_in      = $urandom;
            subkey    = {16'($urandom), 32'($urandom)};
            swap_en   = 1'($urandom);
            cycle();
        end
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        l_in      = '0;
        r_in      = '0;
        subkey    = '0;
        swap_en   = 1'b0;
        test_reset();
        test_kat(1'b1, 32'hF0AAF0AA, 32'hEF4A6544);
        test_kat(1'b0, 32'hEF4A6544, 32'hF0AAF0AA);
        test_stream();
        test_backpressure();
        test_reset_midflight();
        test_sbox_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/des_f_round.md
DES_F_ROUND -- requirements
Module: des_f_round

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed by DES.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream asserts that l_in, r_in, subkey and swap_en are valid.
REQ-005 in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready on a clk edge.
REQ-006 l_in  input  [1:32]  left half, DES bit numbering (bit 1 = MSB).
REQ-007 r_in  input  [1:32]  right half.
REQ-008 subkey  input  [1:48]  round key K_i.
REQ-009 swap_en  input  1  1 = normal round (halves swapped), 0 = final round (no swap).
REQ-010 out_valid  output  1  l_out/r_out hold a completed round result.
REQ-011 out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready on a clk edge.
REQ-012 l_out  output  [1:32]  new left half.
REQ-013 r_out  output  [1:32]  new right half.

Function
REQ-014 Stage 1 SHALL register X = E(r_in) XOR subkey (48 bits, FIPS 46-3 E table) plus l_in, r_in, swap_en and a valid bit s1_v.
REQ-015 Stage 2 SHALL split X into eight 6-bit groups X[1:6]..X[43:48], feed them to the existing s1box..s8box instances in that order, and concatenate the 4-bit outputs to S[1:32].
REQ-016 Stage 2 SHALL compute f = P(S) using the FIPS 46-3 P table; the S-box and P logic SHALL be combinational between the stage registers.
REQ-017 With swap_en=1, the output register SHALL load l_out = R, r_out = L XOR f; with swap_en=0, it SHALL load l_out = L XOR f, r_out = R.
REQ-018 The output register SHALL carry valid bit s2_v, and out_valid SHALL equal s2_v.
REQ-019 Latency SHALL be exactly 2 clk edges from input transfer to out_valid, with out_ready held high.
REQ-020 Throughput SHALL be one round per cycle while out_ready=1.
REQ-021 Advance rule: adv2 = !s2_v || out_ready; adv1 = !s1_v || adv2; in_ready SHALL equal adv1, combinationally.
REQ-022 On adv2, s2 SHALL load from stage 1 with s2_v <= s1_v. On adv1, s1 SHALL load from the inputs with s1_v <= in_valid && in_ready.
REQ-023 While out_valid=1 && out_ready=0, l_out, r_out and out_valid SHALL hold stable, and stage 1 SHALL hold if occupied.
REQ-024 Both stages full and stalled: in_ready SHALL be 0 and no input SHALL be lost or duplicated.
REQ-025 Simultaneous output transfer and input accept in the same cycle SHALL be supported without a bubble.
REQ-026 Data registers SHALL load only when their stage advances; their contents are don't-care when the valid bit is 0.

Reset
REQ-027 While rst_n=0: s1_v=0, s2_v=0, out_valid=0, l_out=0, r_out=0, and stage-1 data=0.
REQ-028 When rst_n=0: in_ready SHALL read 1.
REQ-029 Asserting rst_n mid-operation SHALL discard all in-flight rounds immediately (asynchronously).
REQ-030 After release, the first accepted input SHALL produce out_valid exactly 2 edges later.

Verification
REQ-031 Known-answer test: l_in=CC00CCFF, r_in=F0AAF0AA, subkey=1B02EFFC7072, swap_en=1 -> after 2 cycles l_out=F0AAF0AA, r_out=EF4A6544 (X=6117BA866527, f=234AA9BB).
REQ-032 Same inputs with swap_en=0 -> l_out=EF4A6544, r_out=F0AAF0AA.
REQ-033 Streaming test: 16 back-to-back inputs with out_ready=1 -> 16 outputs on consecutive cycles, in order, with in_ready constantly 1.
REQ-034 Backpressure test: stream 3 inputs and hold out_ready=0 for 5 cycles -> in_ready drops to 0 after 2 accepts, l_out is stable during the stall, and all 3 results emerge in order once out_ready=1.
REQ-035 Reset test: assert rst_n=0 while 2 rounds are in flight -> out_valid=0 and l_out=r_out=0 immediately, and no stale output appears after release.
REQ-036 Exhaustive S-box path test: sweep each 6-bit group of X over 0..63, with all other inputs 0, against a reference f-function model -> all match.
